// File: rtl/int_to_dec.sv
// Iterative integer-to-BCD converter: one divide-by-10 step per cycle, digit 0 first.
// Define INT_TO_DEC_SIGNED_EN for two's-complement input; the default build is unsigned.

`ifndef INT_BITS
`define INT_BITS 32
`endif

module int_to_dec_div10 #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] quo_o,
  output logic [3:0]   rem_o
);
  logic [4:0]   r;
  logic [W-1:0] q;

  // Restoring long division by a constant: the partial remainder never exceeds 19.
  always_comb begin
    r = '0;
    q = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = {r[3:0], x_i[i]};
      if (r >= 5'd10) begin
        r    = r - 5'd10;
        q[i] = 1'b1;
      end
    end
    quo_o = q;
    rem_o = r[3:0];
  end
endmodule

module int_to_dec #(
  parameter int DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [`INT_BITS-1:0]         value,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          digits,
  output logic [$clog2(DIGITS+1)-1:0]  num_digits,
  output logic                         overflow,
  output logic                         negative,
  output logic [1:0]                   dbg_state
);
  localparam int IB  = `INT_BITS;
  localparam int NDW = $clog2(DIGITS + 1);
  localparam logic [NDW-1:0] LAST_IDX = NDW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q;
  logic [IB-1:0]      work_q;
  logic [NDW-1:0]     idx_q;
  logic [4*DIGITS-1:0] digits_q;
  logic [NDW-1:0]     ndig_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [IB-1:0]      mag_d;
  logic [IB-1:0]      quo_d;
  logic [3:0]         rem_d;

`ifdef INT_TO_DEC_SIGNED_EN
  logic neg_d;
  logic neg_q;

  // Unsigned negation keeps the most negative value exact as a magnitude.
  assign neg_d = value[IB-1];
  assign mag_d = neg_d ? (~value + IB'(1)) : value;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      neg_q <= neg_d;
    end
  end

  assign negative = neg_q;
`else
  assign mag_d    = value;
  assign negative = 1'b0;
`endif

  int_to_dec_div10 #(.W(IB)) u_div10 (
    .x_i   (work_q),
    .quo_o (quo_d),
    .rem_o (rem_d)
  );

  // Handshakes: a request transfers on an edge where in_valid && in_ready, a result
  // transfers on an edge where out_valid && out_ready; both flags are registered and
  // each is high only in its own state, so at most one conversion is ever in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      idx_q       <= '0;
      digits_q    <= '0;
      ndig_q      <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q     <= mag_d;
            idx_q      <= '0;
            digits_q   <= '0;
            ndig_q     <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= CONVERT;
          end
        end
        CONVERT: begin
          for (int s = 0; s < DIGITS; s++) begin
            if (idx_q == NDW'(s)) begin
              digits_q[4*s +: 4] <= rem_d;
            end
          end
          work_q <= quo_d;
          idx_q  <= idx_q + 1'b1;
          // A nonzero quotient at the last slot means higher digits are dropped.
          if (quo_d == '0 || idx_q == LAST_IDX) begin
            ndig_q      <= idx_q + 1'b1;
            ovf_q       <= (quo_d != '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign digits     = digits_q;
  assign num_digits = ndig_q;
  assign overflow   = ovf_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_int_to_dec.sv
// Randomized scoreboard bench for int_to_dec; the reference model converts with plain
// integer % and / arithmetic and follows INT_TO_DEC_SIGNED_EN when it is defined.

`ifndef INT_BITS
`define INT_BITS 32
`endif

module tb_int_to_dec;
  localparam int IB     = `INT_BITS;
  localparam int DIGITS = 10;
  localparam int NDW    = $clog2(DIGITS + 1);
  localparam int EW     = 4 * DIGITS + NDW + 2;

  // Clock / reset and DUT signals
  logic                 clk;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [IB-1:0]        value;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*DIGITS-1:0]  digits;
  logic [NDW-1:0]       num_digits;
  logic                 overflow;
  logic                 negative;
  logic [1:0]           dbg_state;

  logic                 in_valid4;
  logic                 in_ready4;
  logic [IB-1:0]        value4;
  logic                 out_valid4;
  logic                 out_ready4;
  logic [15:0]          digits4;
  logic [2:0]           num_digits4;
  logic                 overflow4;
  logic                 negative4;
  logic [1:0]           dbg_state4;

  int n_cmp;
  int n_fail;
  int rdy_mode;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  int_to_dec #(.DIGITS(DIGITS)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .value      (value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .digits     (digits),
    .num_digits (num_digits),
    .overflow   (overflow),
    .negative   (negative),
    .dbg_state  (dbg_state)
  );

  int_to_dec #(.DIGITS(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid4),
    .in_ready   (in_ready4),
    .value      (value4),
    .out_valid  (out_valid4),
    .out_ready  (out_ready4),
    .digits     (digits4),
    .num_digits (num_digits4),
    .overflow   (overflow4),
    .negative   (negative4),
    .dbg_state  (dbg_state4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: decimal digits of the magnitude, least significant first.
  function automatic void model(input logic [IB-1:0] v, input int nmax,
                                output logic [4*DIGITS-1:0] dg, output int nd,
                                output bit ov, output bit ng);
    longint unsigned mag;
    dg  = '0;
    nd  = 0;
    ov  = 1'b0;
    ng  = 1'b0;
    mag = 64'(v);
`ifdef INT_TO_DEC_SIGNED_EN
    if (v[IB-1]) begin
      ng  = 1'b1;
      mag = (64'd1 << IB) - 64'(v);
    end
`endif
    do begin
      if (nd < nmax) begin
        dg[4*nd +: 4] = 4'(mag % 10);
        nd++;
      end else begin
        ov = 1'b1;
      end
      mag = mag / 10;
    end while (mag != 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_idle();
    int k;
    k = 0;
    while (!in_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic send(input logic [IB-1:0] v);
    logic [4*DIGITS-1:0] dg;
    int nd;
    bit ov;
    bit ng;
    int k;
    model(v, DIGITS, dg, nd, ov, ng);
    wait_idle();
    if (!in_ready) return;
    in_valid = 1'b1;
    value    = v;
    exp_q.push_back({dg, NDW'(nd), ov, ng});
    @(posedge clk); #1;
    in_valid = 1'b0;
    value    = $urandom;
    k = 0;
    while (!out_valid && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    else check("latency", 64'(k), 64'(nd));
  endtask

  // Consumer: random backpressure unless a directed test owns out_ready.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {63'd0, out_valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("digits", 64'(digits), 64'(mon_e[EW-1 -: 4*DIGITS]));
        check("num_digits", 64'(num_digits), 64'(mon_e[NDW+1 -: NDW]));
        check("overflow", {63'd0, overflow}, {63'd0, mon_e[1]});
        check("negative", {63'd0, negative}, {63'd0, mon_e[0]});
      end
    end
  end

  initial begin
    logic [4*DIGITS-1:0] dg;
    int nd;
    bit ov;
    bit ng;
    int k;
    n_cmp     = 0;
    n_fail    = 0;
    rdy_mode  = 1;
    reset     = 1'b1;
    in_valid  = 1'b0;
    value     = '0;
    in_valid4 = 1'b0;
    value4    = '0;
    out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_digits", 64'(digits), 64'd0);
    check("rst_num_digits", 64'(num_digits), 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_negative", {63'd0, negative}, 64'd0);

    #1 rdy_mode = 0;
    send('0);
    send('1);
    send(IB'(32'hFFFFFF85));
    send(IB'(32'h80000000));

    // Backpressure: result must hold steady while out_ready stays low.
    wait_idle();
    rdy_mode  = 1;
    out_ready = 1'b0;
    send(IB'(12345));
    model(IB'(12345), DIGITS, dg, nd, ov, ng);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_digits", 64'(digits), 64'(dg));
      check("bp_num_digits", 64'(num_digits), 64'(nd));
      @(posedge clk); #1;
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    #1 rdy_mode = 0;

    for (int i = 0; i < 40; i++) begin
      send(IB'($urandom >> $urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // Reset on the third CONVERT cycle abandons the conversion.
    wait_idle();
    in_valid = 1'b1;
    value    = IB'(98765);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_digits", 64'(digits), 64'd0);
    check("midrst_num_digits", 64'(num_digits), 64'd0);
    check("midrst_overflow", {63'd0, overflow}, 64'd0);
    send(IB'(7));

    // Four-slot instance: 12345 keeps its low four digits and flags overflow.
    k = 0;
    while (!in_ready4 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid4 = 1'b1;
    value4    = IB'(12345);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    k = 0;
    while (!out_valid4 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    model(IB'(12345), 4, dg, nd, ov, ng);
    check("d4_latency", 64'(k), 64'(nd));
    check("d4_out_valid", {63'd0, out_valid4}, 64'd1);
    check("d4_digits", 64'(digits4), 64'(dg[15:0]));
    check("d4_num_digits", 64'(num_digits4), 64'(nd));
    check("d4_overflow", {63'd0, overflow4}, {63'd0, ov});

    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
